// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, default sizes and the per-digit add-3 correction.
package bin2bcd_pkg;

    // Default binary width and digit count; 10 digits cover 4294967295.
    localparam int BCD_WIDTH  = 32;
    localparam int BCD_DIGITS = 10;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Double-dabble correction for one BCD digit. A digit of 5 or more
    // becomes 8 or more, so the following left shift carries into the
    // next digit. The add stays inside the nibble with no carry out.
    function automatic logic [3:0] add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Combinational add-3 correction for a single BCD digit of the accumulator.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    // Pure function of the current digit; no state.
    assign adjusted = add3(nibble);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one shift per clock).
// A start strobe in IDLE captures valor; WIDTH shifts later the packed
// digits are copied to bcd with a one-cycle done pulse. bcd only changes
// on that DONE edge, so a downstream display never sees partial results.
//
// Handshake: output_flag is level-sampled on every rising edge and is
// accepted only while the FSM is IDLE (busy=0), including the cycle in
// which done is high. While busy=1 it is ignored with no queueing. done
// is high for exactly one cycle per completed conversion; valid is sticky
// from the first completion until reset.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      valor,
    input  logic                  output_flag,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  valid
);
    import bin2bcd_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    sreg;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_adj;
    logic [AW+WIDTH-1:0] shifted;
    logic                last_shift;

    // One correction unit per digit, all digits adjusted in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .nibble   (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    // Corrected accumulator and remaining binary bits shifted as one word.
    assign shifted    = {acc_adj, sreg} << 1;
    assign last_shift = (count == CW'(WIDTH - 1));
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH edges, DONE for one.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (output_flag) next_state = SHIFT;
            SHIFT:   if (last_shift)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture on start, shift during SHIFT, publish result in DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg  <= '0;
            acc   <= '0;
            count <= '0;
            bcd   <= '0;
            done  <= 1'b0;
            valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (output_flag) begin
                        sreg  <= valor;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    acc   <= shifted[AW+WIDTH-1:WIDTH];
                    sreg  <= shifted[WIDTH-1:0];
                    count <= count + CW'(1);
                end
                DONE: begin
                    bcd   <= acc;
                    done  <= 1'b1;
                    valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, busy window, extreme values,
// ignored restarts, back-to-back starts and asynchronous reset.
module tb_bin2bcd_seq;

    logic        clock;
    logic        reset_n;
    logic [31:0] valor;
    logic        output_flag;
    logic [39:0] bcd;
    logic        busy;
    logic        done;
    logic        valid;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .valor       (valor),
        .output_flag (output_flag),
        .bcd         (bcd),
        .busy        (busy),
        .done        (done),
        .valid       (valid)
    );

    // Clock: 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle start strobe; returns at the negedge after the
    // accepting edge, then scrambles valor to prove it is not re-sampled.
    task automatic start(input logic [31:0] value);
        @(negedge clock);
        valor       = value;
        output_flag = 1'b1;
        @(negedge clock);
        output_flag = 1'b0;
        valor       = ~value;
    endtask

    // Count negedges until done is seen (bounded); also count busy samples.
    task automatic wait_done(output int edges, output int busy_hi);
        edges   = 0;
        busy_hi = 0;
        while (edges < 100) begin
            @(negedge clock);
            edges++;
            if (busy) busy_hi++;
            if (done) break;
        end
    endtask

    int edges;
    int busy_hi;
    int done_cnt;
    int bad_hold;

    initial begin
        reset_n     = 1'b0;
        valor       = '0;
        output_flag = 1'b0;

        // Reset state.
        #12;
        check("reset_bcd",   {24'd0, bcd}, 64'h0);
        check("reset_busy",  {63'd0, busy}, 64'd0);
        check("reset_done",  {63'd0, done}, 64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1. Zero input: done 33 edges after the start edge.
        start(32'd0);
        check("t1_busy_after_start", {63'd0, busy}, 64'd1);
        wait_done(edges, busy_hi);
        check("t1_latency", 64'(edges), 64'd33);
        check("t1_bcd",     {24'd0, bcd}, 64'h0);
        check("t1_valid",   {63'd0, valid}, 64'd1);
        @(negedge clock);
        check("t1_done_one_cycle", {63'd0, done}, 64'd0);

        // 2. 42: busy high for exactly 33 edges (start edge + 32 shifts).
        start(32'd42);
        check("t2_busy_after_start", {63'd0, busy}, 64'd1);
        wait_done(edges, busy_hi);
        check("t2_latency", 64'(edges), 64'd33);
        check("t2_busy_edges", 64'(busy_hi + 1), 64'd33);
        check("t2_busy_low_at_done", {63'd0, busy}, 64'd0);
        check("t2_bcd", {24'd0, bcd}, 64'h42);

        // 3. Maximum value.
        start(32'hFFFF_FFFF);
        wait_done(edges, busy_hi);
        check("t3_latency", 64'(edges), 64'd33);
        check("t3_bcd", {24'd0, bcd}, 64'h42_9496_7295);

        // 4. Start 1234, retrigger with 99 at edge N+10: ignored.
        start(32'd1234);
        repeat (9) @(negedge clock);
        valor       = 32'd99;
        output_flag = 1'b1;
        @(negedge clock);
        output_flag = 1'b0;
        check("t4_bcd_held_old", {24'd0, bcd}, 64'h42_9496_7295);
        wait_done(edges, busy_hi);
        check("t4_latency_rest", 64'(edges), 64'd23);
        check("t4_bcd", {24'd0, bcd}, 64'h1234);

        // 5. Back-to-back: start accepted in the done cycle.
        valor       = 32'd5;
        output_flag = 1'b1;
        @(negedge clock);
        output_flag = 1'b0;
        valor       = 32'd77;
        check("t5_busy_after_start", {63'd0, busy}, 64'd1);
        check("t5_done_cleared",     {63'd0, done}, 64'd0);
        edges    = 0;
        bad_hold = 0;
        done_cnt = 0;
        while (edges < 100) begin
            @(negedge clock);
            edges++;
            if (done) begin
                done_cnt++;
                break;
            end
            if (bcd !== 40'h1234) bad_hold++;
        end
        check("t5_latency",  64'(edges), 64'd33);
        check("t5_bcd_hold", 64'(bad_hold), 64'd0);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);
        check("t5_bcd",      {24'd0, bcd}, 64'h5);

        // 6. Asynchronous reset mid-SHIFT, then a fresh conversion.
        start(32'd7777);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_bcd",   {24'd0, bcd}, 64'h0);
        check("t6_rst_busy",  {63'd0, busy}, 64'd0);
        check("t6_rst_valid", {63'd0, valid}, 64'd0);
        check("t6_rst_done",  {63'd0, done}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("t6_no_done_after_rst", 64'(done_cnt), 64'd0);
        check("t6_valid_still_low",   {63'd0, valid}, 64'd0);
        start(32'd65535);
        wait_done(edges, busy_hi);
        check("t6_latency", 64'(edges), 64'd33);
        check("t6_bcd",     {24'd0, bcd}, 64'h65535);
        check("t6_valid",   {63'd0, valid}, 64'd1);

        // Extra pattern exercising zeros between digits.
        start(32'd1000000);
        wait_done(edges, busy_hi);
        check("t7_bcd", {24'd0, bcd}, 64'h100_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
